// File: rtl/lcd_pixel_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pixel_pkg
// Shared definitions for the FIFO -> LCD pixel path.
//  - WORD_WIDTH / PIXEL_WIDTH : FIFO word and RGB pixel widths (32 / 24).
//  - phase_e                  : unpack phase, named after the number of carry
//                               bytes held (C0..C3).
//  - LANE1..LANE3             : byte-lane widths used when splitting a packed
//                               word. The ingester-side test model uses them too.
//  - unpack_step()            : one step of the 3-word -> 4-pixel unpacking.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_pixel_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int PIXEL_WIDTH = 24;
  localparam int BYTE_WIDTH  = 8;

  // Lane widths: the number of bits carried out of a word in phases C0, C1, C2.
  localparam int LANE1 = BYTE_WIDTH;
  localparam int LANE2 = 2 * BYTE_WIDTH;
  localparam int LANE3 = 3 * BYTE_WIDTH;

  typedef enum logic [1:0] {
    PH_C0 = 2'd0,
    PH_C1 = 2'd1,
    PH_C2 = 2'd2,
    PH_C3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] pixel;
    logic [PIXEL_WIDTH-1:0] carry;
    phase_e                 next_phase;
  } unpack_t;

  // Pixel, new carry and next phase for the current phase. In C3 the word is
  // ignored because the whole pixel is already sitting in the carry.
  function automatic unpack_t unpack_step(input phase_e                 ph,
                                          input logic [PIXEL_WIDTH-1:0] carry,
                                          input logic [WORD_WIDTH-1:0]  word);
    unpack_t r;
    r.pixel      = '0;
    r.carry      = '0;
    r.next_phase = PH_C0;
    case (ph)
      PH_C0: begin
        r.pixel              = word[WORD_WIDTH-1 -: LANE3];
        r.carry[LANE1-1:0]   = word[LANE1-1:0];
        r.next_phase         = PH_C1;
      end
      PH_C1: begin
        r.pixel              = {carry[LANE1-1:0], word[WORD_WIDTH-1 -: LANE2]};
        r.carry[LANE2-1:0]   = word[LANE2-1:0];
        r.next_phase         = PH_C2;
      end
      PH_C2: begin
        r.pixel              = {carry[LANE2-1:0], word[WORD_WIDTH-1 -: LANE1]};
        r.carry              = word[LANE3-1:0];
        r.next_phase         = PH_C3;
      end
      default: begin
        r.pixel              = carry;
        r.next_phase         = PH_C0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/word_skid_fifo2.sv
// ---------------------------------------------------------------------------
// word_skid_fifo2
// Two-entry word buffer between the FIFO read port and the unpacker.
// Ports:
//  i_clock  in   clock
//  i_reset  in   asynchronous active-high reset (empties the buffer)
//  i_push   in   write i_data at this edge
//  i_data   in   word to store
//  i_pop    in   drop the head word at this edge (only when o_count != 0)
//  o_head   out  oldest stored word
//  o_count  out  number of stored words (0..2)
// The caller never pushes into a full buffer: its read requests already
// reserve room for every word in flight.
// ---------------------------------------------------------------------------
module word_skid_fifo2
  import lcd_pixel_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Storage needs no reset: the occupancy count says which entries are valid.
  always_ff @(posedge i_clock) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (i_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (i_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fifo_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_pixel_unpacker
// Pops 32-bit packed words from the frame FIFO (non-FWFT) and unpacks them
// into 24-bit RGB pixels. Three words always yield four pixels.
// Ports:
//  i_clock           in   FIFO read clock
//  i_reset           in   asynchronous active-high reset
//  i_fifoData        in   FIFO read data, valid one cycle after a pop
//  i_fifoEmpty       in   FIFO empty flag
//  o_fifoReadEnable  out  FIFO pop request
//  o_pixelData       out  RGB pixel (R in the MSBs)
//  o_pixelValid      out  o_pixelData holds a valid pixel
//  i_pixelReady      in   downstream takes the pixel when valid && ready
//  o_phase           out  current unpack phase (debug)
//  i_realign         in   present only when UNPACK_REALIGN_EN is defined;
//                         drops the carry and restarts the pixel group
// Optional feature macro: UNPACK_REALIGN_EN.
// ---------------------------------------------------------------------------
module fifo_pixel_unpacker #(
  parameter int WORD_WIDTH  = lcd_pixel_pkg::WORD_WIDTH,
  parameter int PIXEL_WIDTH = lcd_pixel_pkg::PIXEL_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [WORD_WIDTH-1:0]  i_fifoData,
  input  logic                   i_fifoEmpty,
  output logic                   o_fifoReadEnable,
  output logic [PIXEL_WIDTH-1:0] o_pixelData,
  output logic                   o_pixelValid,
  input  logic                   i_pixelReady,
  output logic [1:0]             o_phase
`ifdef UNPACK_REALIGN_EN
  ,
  input  logic                   i_realign
`endif
);

  import lcd_pixel_pkg::*;

  // The unpacking lanes are fixed to the 32 -> 24 layout.
  generate
    if (WORD_WIDTH != 32 || PIXEL_WIDTH != 24) begin : g_bad_cfg
      $error("fifo_pixel_unpacker supports only WORD_WIDTH=32 and PIXEL_WIDTH=24");
    end
  endgenerate

  logic realign;
`ifdef UNPACK_REALIGN_EN
  assign realign = i_realign;
`else
  assign realign = 1'b0;
`endif

  logic [WORD_WIDTH-1:0]  head_word;
  logic [1:0]             buf_count;
  logic                   rd_inflight_q;
  logic                   load_en;
  logic                   consume;
  logic [1:0]             committed;
  unpack_t                step;

  phase_e                 phase_q;
  logic [PIXEL_WIDTH-1:0] carry_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic                   valid_q;

  // A read returns its word one cycle later. That word goes into the buffer
  // at the following edge. It is not passed straight to the pixel register.
  word_skid_fifo2 #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (rd_inflight_q),
    .i_data  (i_fifoData),
    .i_pop   (consume),
    .o_head  (head_word),
    .o_count (buf_count)
  );

  always_comb begin
    // C3 needs no word; the other phases need a buffered one.
    // Realign wins over a load.
    load_en   = (!valid_q || i_pixelReady)
              && ((phase_q == PH_C3) || (buf_count != 2'd0))
              && !realign;
    consume   = load_en && (phase_q != PH_C3);
    // Words that will occupy the buffer after this edge. consume implies
    // buf_count >= 1, and count + in-flight never exceeds 2, so no wrap.
    committed = buf_count + {1'b0, rd_inflight_q} - {1'b0, consume};
    o_fifoReadEnable = !i_fifoEmpty && (committed < 2'd2);
    step      = unpack_step(phase_q, carry_q, head_word);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_inflight_q <= 1'b0;
      phase_q       <= PH_C0;
      carry_q       <= '0;
      pixel_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      rd_inflight_q <= o_fifoReadEnable;
      if (realign) begin
        // Buffered and in-flight words are kept; they start the new group.
        phase_q <= PH_C0;
        carry_q <= '0;
        pixel_q <= '0;
        valid_q <= 1'b0;
      end else if (load_en) begin
        phase_q <= step.next_phase;
        carry_q <= step.carry;
        pixel_q <= step.pixel;
        valid_q <= 1'b1;
      end else if (valid_q && i_pixelReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_pixelData  = pixel_q;
  assign o_pixelValid = valid_q;
  assign o_phase      = phase_q;

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
module tb_fifo_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_data = 32'h0;
  logic        fifo_empty;
  logic        rd_en;
  logic [23:0] pix;
  logic        pix_valid;
  logic        pix_ready;
  logic [1:0]  phase;
`ifdef UNPACK_REALIGN_EN
  logic        realign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: tasks own wr_idx, the model owns rd_idx.
  logic [31:0] fifo_mem [0:8191];
  int          wr_idx = 0;
  int          rd_idx = 0;
  logic        force_empty;

  // Monitor-owned capture of accepted pixels and read strobes.
  logic [23:0] got_mem [0:8191];
  int          got_n        = 0;
  int          rd_cnt       = 0;
  int          rd_empty_err = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx) || force_empty;

  fifo_pixel_unpacker dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_fifoData       (fifo_data),
    .i_fifoEmpty      (fifo_empty),
    .o_fifoReadEnable (rd_en),
    .o_pixelData      (pix),
    .o_pixelValid     (pix_valid),
    .i_pixelReady     (pix_ready),
    .o_phase          (phase)
`ifdef UNPACK_REALIGN_EN
    ,
    .i_realign        (realign)
`endif
  );

  // Non-FWFT FIFO: data appears the cycle after the pop.
  always @(posedge clk) begin
    if (rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && pix_ready) begin
        got_mem[got_n] <= pix;
        got_n          <= got_n + 1;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (fifo_empty) rd_empty_err <= rd_empty_err + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_idx] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    wr_idx      = rd_idx;
    force_empty = 1'b0;
    pix_ready   = 1'b1;
`ifdef UNPACK_REALIGN_EN
    realign     = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for n accepted pixels since base; compares them with exp.
  task automatic expect_pixels(input string name, input int base, input int n,
                               input logic [23:0] exp [8]);
    int cyc;
    cyc = 0;
    while ((got_n - base) < n && cyc < 60) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ((got_n - base) < n) begin
      n_fail++;
      $display("FAIL %s_count got %0d pixels, expected %0d", name, got_n - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (got_mem[base + i] !== exp[i]) begin
          n_fail++;
          $display("FAIL %s_pix[%0d] got %h expected %h", name, i, got_mem[base + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_ready = 1'b1; force_empty = 1'b0;
`ifdef UNPACK_REALIGN_EN
    realign = 1'b0;
`endif
    #1;
    n_checks++;
    if (pix_valid !== 1'b0 || pix !== 24'h0 || phase !== 2'd0 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state valid=%b data=%h phase=%0d rd=%b expected 0/000000/0/0",
               pix_valid, pix, phase, rd_en);
    end
    $display("test_reset: valid=%b data=%h phase=%0d", pix_valid, pix, phase);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [23:0] exp_pix [4];
    int          rd0;
    exp_pix[0] = 24'hAABBCC; exp_pix[1] = 24'hDDEEFF;
    exp_pix[2] = 24'h001122; exp_pix[3] = 24'h334455;
    do_reset();
    rd0 = rd_cnt;
    push_word(32'hAABBCCDD); push_word(32'hEEFF0011); push_word(32'h22334455);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (c >= 3 && c <= 6) begin
        if (pix_valid !== 1'b1 || pix !== exp_pix[c-3]) begin
          n_fail++;
          $display("FAIL stream_c%0d valid=%b data=%h expected valid=1 data=%h",
                   c, pix_valid, pix, exp_pix[c-3]);
        end
      end else if (pix_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_c%0d valid=%b expected 0", c, pix_valid);
      end
    end
    #1;
    n_checks++;
    if (rd_cnt - rd0 != 3) begin
      n_fail++;
      $display("FAIL stream_reads got %0d rd_en pulses expected 3", rd_cnt - rd0);
    end
    $display("test_stream: %0d rd_en pulses", rd_cnt - rd0);
  endtask

  task automatic test_backpressure();
    logic [23:0] exp_pix [8];
    int          base;
    exp_pix[0] = 24'hAABBCC; exp_pix[1] = 24'hDDEEFF;
    exp_pix[2] = 24'h001122; exp_pix[3] = 24'h334455;
    exp_pix[4] = 24'h667788; exp_pix[5] = 24'h99AABB;
    exp_pix[6] = 24'hCCDDEE; exp_pix[7] = 24'hFF0102;
    do_reset();
    pix_ready = 1'b0;
    base = got_n;
    push_word(32'hAABBCCDD); push_word(32'hEEFF0011); push_word(32'h22334455);
    push_word(32'h66778899); push_word(32'hAABBCCDD); push_word(32'hEEFF0102);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix !== 24'hAABBCC || phase !== 2'd1) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d valid=%b data=%h phase=%0d expected 1/aabbcc/1",
                   c, pix_valid, pix, phase);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (rd_en !== 1'b0 || fifo_empty !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full_c%0d rd_en=%b empty=%b expected rd_en=0 empty=0",
                   c, rd_en, fifo_empty);
        end
      end
    end
    tick();
    pix_ready = 1'b1;
    expect_pixels("bp", base, 8, exp_pix);
    $display("test_backpressure: %0d pixels after release", got_n - base);
  endtask

  task automatic test_underflow();
    int cyc;
    do_reset();
    push_word(32'hAABBCCDD);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix !== 24'hAABBCC) begin
          n_fail++;
          $display("FAIL uf_first valid=%b data=%h expected 1/aabbcc", pix_valid, pix);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (pix_valid !== 1'b0 || phase !== 2'd1) begin
          n_fail++;
          $display("FAIL uf_idle_c%0d valid=%b phase=%0d expected 0/1", c, pix_valid, phase);
        end
      end
    end
    tick();
    push_word(32'hEEFF0011);
    cyc = 0;
    @(negedge clk);
    while (pix_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (pix_valid !== 1'b1 || pix !== 24'hDDEEFF || phase !== 2'd2) begin
      n_fail++;
      $display("FAIL uf_resume valid=%b data=%h phase=%0d expected 1/ddeeff/2",
               pix_valid, pix, phase);
    end
    $display("test_underflow: resumed pixel %h", pix);
  endtask

  task automatic test_async_reset();
    logic [23:0] exp_pix [8];
    int          base;
    exp_pix[0] = 24'h010203; exp_pix[1] = 24'h040506;
    exp_pix[2] = 24'h070809; exp_pix[3] = 24'h0A0B0C;
    for (int i = 4; i < 8; i++) exp_pix[i] = 24'h0;
    do_reset();
    push_word(32'hAABBCCDD); push_word(32'hEEFF0011); push_word(32'h22334455);
    for (int c = 0; c < 5; c++) @(negedge clk);
    n_checks++;
    if (pix_valid !== 1'b1 || pix !== 24'hDDEEFF || phase !== 2'd2) begin
      n_fail++;
      $display("FAIL ar_pre valid=%b data=%h phase=%0d expected 1/ddeeff/2", pix_valid, pix, phase);
    end
    #2;
    rst    = 1'b1;
    wr_idx = rd_idx;
    #1;
    n_checks++;
    if (pix_valid !== 1'b0 || pix !== 24'h0 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_async valid=%b data=%h phase=%0d expected 0/000000/0", pix_valid, pix, phase);
    end
    tick();
    rst  = 1'b0;
    base = got_n;
    push_word(32'h01020304); push_word(32'h05060708); push_word(32'h090A0B0C);
    expect_pixels("ar", base, 4, exp_pix);
    $display("test_async_reset: %0d pixels after reset", got_n - base);
  endtask

`ifdef UNPACK_REALIGN_EN
  task automatic test_realign();
    logic [23:0] exp_pix [8];
    int          base;
    exp_pix[0] = 24'h112233; exp_pix[1] = 24'h445566;
    exp_pix[2] = 24'h778899; exp_pix[3] = 24'hAABBCC;
    for (int i = 4; i < 8; i++) exp_pix[i] = 24'h0;
    do_reset();
    push_word(32'hAABBCCDD);
    for (int c = 0; c < 5; c++) @(negedge clk);
    n_checks++;
    if (phase !== 2'd1) begin
      n_fail++;
      $display("FAIL ra_pre phase=%0d expected 1", phase);
    end
    tick();
    realign = 1'b1;
    tick();
    realign = 1'b0;
    n_checks++;
    if (phase !== 2'd0 || pix_valid !== 1'b0 || pix !== 24'h0) begin
      n_fail++;
      $display("FAIL ra_clear phase=%0d valid=%b data=%h expected 0/0/000000", phase, pix_valid, pix);
    end
    base = got_n;
    push_word(32'h11223344); push_word(32'h55667788); push_word(32'h99AABBCC);
    expect_pixels("ra", base, 4, exp_pix);
    $display("test_realign: %0d pixels after realign", got_n - base);
  endtask
`endif

  task automatic test_random();
    logic [7:0]  bytes [12000];
    logic [31:0] w;
    logic [23:0] e;
    int          base;
    int          err0;
    int          cyc;
    do_reset();
    base = got_n;
    err0 = rd_empty_err;
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      push_word(w);
      for (int b = 0; b < 4; b++) bytes[4*i + b] = w[31 - 8*b -: 8];
    end
    cyc = 0;
    while ((got_n - base) < 4000 && cyc < 40000) begin
      force_empty = ($urandom_range(0, 3) == 0);
      pix_ready   = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    force_empty = 1'b0;
    pix_ready   = 1'b1;
    n_checks++;
    if ((got_n - base) != 4000) begin
      n_fail++;
      $display("FAIL rand_count got %0d pixels expected 4000", got_n - base);
    end
    for (int k = 0; k < 4000 && k < (got_n - base); k++) begin
      e = {bytes[3*k], bytes[3*k + 1], bytes[3*k + 2]};
      n_checks++;
      if (got_mem[base + k] !== e) begin
        n_fail++;
        $display("FAIL rand_pix[%0d] got %h expected %h", k, got_mem[base + k], e);
      end
    end
    n_checks++;
    if (rd_empty_err != err0) begin
      n_fail++;
      $display("FAIL rand_read_empty got %0d reads while empty expected 0", rd_empty_err - err0);
    end
    n_checks++;
    if (rd_idx != wr_idx) begin
      n_fail++;
      $display("FAIL rand_drain got %0d words left expected 0", wr_idx - rd_idx);
    end
    $display("test_random: %0d pixels in %0d cycles", got_n - base, cyc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_underflow();
    test_async_reset();
`ifdef UNPACK_REALIGN_EN
    test_realign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
